// File: rtl/rv32_pkg.sv
// Shared RV32I encoder types: request bundle, opcode/ALU/branch enums,
// base opcodes and immediate range limits.
package rv32_pkg;

    typedef enum logic [3:0] {
        OP_LUI    = 4'd0,
        OP_AUIPC  = 4'd1,
        OP_JAL    = 4'd2,
        OP_JALR   = 4'd3,
        OP_BRANCH = 4'd4,
        OP_LOAD   = 4'd5,
        OP_STORE  = 4'd6,
        OP_IMM    = 4'd7,
        OP_REG    = 4'd8,
        OP_LI     = 4'd9
    } opcode_e;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } alu_op_e;

    // Values double as the branch funct3 field.
    typedef enum logic [2:0] {
        BR_EQ  = 3'd0,
        BR_NE  = 3'd1,
        BR_LT  = 3'd4,
        BR_GE  = 3'd5,
        BR_LTU = 3'd6,
        BR_GEU = 3'd7
    } branch_op_e;

    typedef struct packed {
        opcode_e    opcode;
        alu_op_e    alu_op;
        branch_op_e branch_op;
        logic [2:0] mem_size;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [31:0] imm;
    } enc_req_t;

    localparam logic [31:0] NOP = 32'h0000_0013;

    localparam logic [6:0] OPC_LUI    = 7'h37;
    localparam logic [6:0] OPC_AUIPC  = 7'h17;
    localparam logic [6:0] OPC_JAL    = 7'h6F;
    localparam logic [6:0] OPC_JALR   = 7'h67;
    localparam logic [6:0] OPC_BRANCH = 7'h63;
    localparam logic [6:0] OPC_LOAD   = 7'h03;
    localparam logic [6:0] OPC_STORE  = 7'h23;
    localparam logic [6:0] OPC_IMM    = 7'h13;
    localparam logic [6:0] OPC_REG    = 7'h33;

    localparam int IMM_I_MIN = -2048;
    localparam int IMM_I_MAX = 2047;
    localparam int IMM_B_MIN = -4096;
    localparam int IMM_B_MAX = 4094;
    localparam int IMM_J_MIN = -1048576;
    localparam int IMM_J_MAX = 1048574;
    localparam int SHAMT_MAX = 31;

    function automatic logic in_range(
        input logic [31:0] v,
        input int          lo,
        input int          hi
    );
        return ($signed(v) >= lo) && ($signed(v) <= hi);
    endfunction

    function automatic logic [2:0] alu_f3(input alu_op_e op);
        logic [2:0] f3;
        f3 = 3'd0;
        unique case (op)
            ALU_ADD, ALU_SUB: f3 = 3'd0;
            ALU_SLL:          f3 = 3'd1;
            ALU_SLT:          f3 = 3'd2;
            ALU_SLTU:         f3 = 3'd3;
            ALU_XOR:          f3 = 3'd4;
            ALU_SRL, ALU_SRA: f3 = 3'd5;
            ALU_OR:           f3 = 3'd6;
            ALU_AND:          f3 = 3'd7;
            default:          f3 = 3'd0;
        endcase
        return f3;
    endfunction

endpackage

// File: rtl/instr_pack.sv
// Combinational packer: one enc_req_t to one RV32I word plus error flag.
// Illegal ops always give NOP; out-of-range immediates follow ERR_ON_TRUNC.
module instr_pack
    import rv32_pkg::*;
#(
    parameter bit ERR_ON_TRUNC = 1'b1
) (
    input  enc_req_t    req_i,
    output logic [31:0] word_o,
    output logic        err_o
);

    logic [31:0] imm;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  ms;
    logic [31:0] raw;
    logic        illegal;
    logic        oor;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic        alu_ok;
    logic        is_shift;

    assign imm = req_i.imm;
    assign rd  = req_i.rd;
    assign rs1 = req_i.rs1;
    assign rs2 = req_i.rs2;
    assign ms  = req_i.mem_size;

    assign alu_ok   = req_i.alu_op <= ALU_AND;
    assign is_shift = req_i.alu_op inside {ALU_SLL, ALU_SRL, ALU_SRA};

    always_comb begin
        raw     = '0;
        illegal = 1'b0;
        oor     = 1'b0;
        f3      = alu_f3(req_i.alu_op);
        f7      = '0;
        unique case (req_i.opcode)
            OP_LUI, OP_AUIPC: begin
                oor = imm[11:0] != 12'h000;
                raw = {imm[31:12], rd,
                       (req_i.opcode == OP_LUI) ? OPC_LUI : OPC_AUIPC};
            end
            OP_JAL: begin
                oor = !in_range(imm, IMM_J_MIN, IMM_J_MAX) || imm[0];
                raw = {imm[20], imm[10:1], imm[11], imm[19:12],
                       rd, OPC_JAL};
            end
            OP_JALR: begin
                oor = !in_range(imm, IMM_I_MIN, IMM_I_MAX);
                raw = {imm[11:0], rs1, 3'b000, rd, OPC_JALR};
            end
            OP_BRANCH: begin
                illegal = !(req_i.branch_op inside
                            {BR_EQ, BR_NE, BR_LT, BR_GE, BR_LTU, BR_GEU});
                oor = !in_range(imm, IMM_B_MIN, IMM_B_MAX) || imm[0];
                raw = {imm[12], imm[10:5], rs2, rs1, req_i.branch_op,
                       imm[4:1], imm[11], OPC_BRANCH};
            end
            OP_LOAD: begin
                illegal = !(ms inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
                oor = !in_range(imm, IMM_I_MIN, IMM_I_MAX);
                raw = {imm[11:0], rs1, ms, rd, OPC_LOAD};
            end
            OP_STORE: begin
                illegal = ms > 3'd2;
                oor = !in_range(imm, IMM_I_MIN, IMM_I_MAX);
                raw = {imm[11:5], rs2, rs1, ms, imm[4:0], OPC_STORE};
            end
            OP_IMM: begin
                // No SUBI in RV32I; a negative ADDI immediate covers it.
                illegal = !alu_ok || (req_i.alu_op == ALU_SUB);
                if (is_shift) begin
                    oor = imm > 32'(SHAMT_MAX);
                    f7  = {1'b0, req_i.alu_op == ALU_SRA, 5'b0};
                    raw = {f7, imm[4:0], rs1, f3, rd, OPC_IMM};
                end else begin
                    oor = !in_range(imm, IMM_I_MIN, IMM_I_MAX);
                    raw = {imm[11:0], rs1, f3, rd, OPC_IMM};
                end
            end
            OP_REG: begin
                illegal = !alu_ok;
                f7 = {1'b0,
                      req_i.alu_op inside {ALU_SUB, ALU_SRA},
                      5'b0};
                raw = {f7, rs2, rs1, f3, rd, OPC_REG};
            end
            default: illegal = 1'b1;
        endcase
    end

    assign word_o = (illegal || (oor && ERR_ON_TRUNC)) ? NOP : raw;
    assign err_o  = illegal || oor;

endmodule

// File: rtl/instr_encoder.sv
// RV32I instruction encoder with one-word output register and handshake.
// RV32_ENC_PSEUDO_EN adds the LI pseudo-op (LUI+ADDI split via S_LI_HI).
module instr_encoder
    import rv32_pkg::*;
#(
    parameter bit ERR_ON_TRUNC = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  enc_req_t    req_i,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic [31:0] instr_o,
    output logic        instr_last_o,
    output logic        err_o
);

`ifdef RV32_ENC_PSEUDO_EN
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ONE   = 2'd1,
        S_LI_HI = 2'd2
    } state_e;
`else
    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_ONE  = 1'b1
    } state_e;
`endif

    state_e      state_q, state_d;
    logic [31:0] word_q, word_d;
    logic        err_q, err_d;
    enc_req_t    pack_req;
    logic [31:0] pack_word;
    logic        pack_err;
    logic        accept;

`ifdef RV32_ENC_PSEUDO_EN
    logic        last_q, last_d;
    logic [11:0] lo_q, lo_d;
    logic [4:0]  lrd_q, lrd_d;
    logic        split;
    logic [19:0] li_hi;
    logic [31:0] addi_word;

    // Upper part rounds up when the low 12 bits sign-extend negative.
    assign li_hi     = req_i.imm[31:12] + {19'b0, req_i.imm[11]};
    assign addi_word = {lo_q, lrd_q, 3'b000, lrd_q, OPC_IMM};

    always_comb begin
        pack_req = req_i;
        split    = 1'b0;
        if (req_i.opcode == OP_LI) begin
            if (in_range(req_i.imm, IMM_I_MIN, IMM_I_MAX)) begin
                pack_req.opcode = OP_IMM;
                pack_req.alu_op = ALU_ADD;
                pack_req.rs1    = 5'd0;
            end else begin
                pack_req.opcode = OP_LUI;
                pack_req.imm    = {li_hi, 12'h000};
                split           = req_i.imm[11:0] != 12'h000;
            end
        end
    end
`else
    assign pack_req = req_i;
`endif

    instr_pack #(
        .ERR_ON_TRUNC(ERR_ON_TRUNC)
    ) u_pack (
        .req_i (pack_req),
        .word_o(pack_word),
        .err_o (pack_err)
    );

    assign req_ready_o = (state_q == S_IDLE) ||
                         ((state_q == S_ONE) && instr_ready_i);
    assign accept      = req_valid_i && req_ready_o;

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        err_d   = err_q;
`ifdef RV32_ENC_PSEUDO_EN
        last_d  = last_q;
        lo_d    = lo_q;
        lrd_d   = lrd_q;
`endif
        if (accept) begin
            word_d  = pack_word;
            err_d   = pack_err;
`ifdef RV32_ENC_PSEUDO_EN
            last_d  = !split;
            lo_d    = req_i.imm[11:0];
            lrd_d   = req_i.rd;
            state_d = split ? S_LI_HI : S_ONE;
`else
            state_d = S_ONE;
`endif
        end else begin
            unique case (state_q)
                S_ONE: begin
                    if (instr_ready_i) state_d = S_IDLE;
                end
`ifdef RV32_ENC_PSEUDO_EN
                S_LI_HI: begin
                    if (instr_ready_i) begin
                        state_d = S_ONE;
                        word_d  = addi_word;
                        err_d   = 1'b0;
                        last_d  = 1'b1;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            word_q  <= '0;
            err_q   <= 1'b0;
`ifdef RV32_ENC_PSEUDO_EN
            last_q  <= 1'b0;
            lo_q    <= '0;
            lrd_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            err_q   <= err_d;
`ifdef RV32_ENC_PSEUDO_EN
            last_q  <= last_d;
            lo_q    <= lo_d;
            lrd_q   <= lrd_d;
`endif
        end
    end

    assign instr_valid_o = state_q != S_IDLE;
    assign instr_o       = word_q;
    assign err_o         = err_q;
`ifdef RV32_ENC_PSEUDO_EN
    assign instr_last_o  = last_q;
`else
    // Every word is final; low only while reset is held.
    assign instr_last_o  = rst_ni;
`endif

endmodule

// File: tb/tb_instr_encoder.sv
// Directed and randomized checks of instr_encoder against a
// behavioural RV32I encoding model.
module tb_instr_encoder;
    import rv32_pkg::*;

    localparam bit EOT   = 1'b1;
    localparam int LIMIT = 20000;

    typedef struct packed {
        logic        err;
        logic        last;
        logic [31:0] w;
    } exp_t;

    logic        clk;
    logic        rst_ni;
    logic        req_valid_i;
    logic        req_ready_o;
    enc_req_t    req_i;
    logic        instr_valid_o;
    logic        instr_ready_i;
    logic [31:0] instr_o;
    logic        instr_last_o;
    logic        err_o;

    int total = 0;
    int bad   = 0;
    exp_t expq[$];

    instr_encoder #(
        .ERR_ON_TRUNC(EOT)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_i        (req_i),
        .instr_valid_o(instr_valid_o),
        .instr_ready_i(instr_ready_i),
        .instr_o      (instr_o),
        .instr_last_o (instr_last_o),
        .err_o        (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    function automatic enc_req_t mk(input opcode_e op, input alu_op_e a,
                                    input branch_op_e b, input logic [2:0] ms,
                                    input logic [4:0] rd, input logic [4:0] rs1,
                                    input logic [4:0] rs2, input logic [31:0] imm);
        enc_req_t r;
        r.opcode = op;    r.alu_op = a;   r.branch_op = b;
        r.mem_size = ms;  r.rd = rd;      r.rs1 = rs1;
        r.rs2 = rs2;      r.imm = imm;
        return r;
    endfunction

    function automatic logic [31:0] f3_of(input alu_op_e a);
        case (a)
            ALU_ADD, ALU_SUB: return 32'd0;
            ALU_SLL:          return 32'd1;
            ALU_SLT:          return 32'd2;
            ALU_SLTU:         return 32'd3;
            ALU_XOR:          return 32'd4;
            ALU_SRL, ALU_SRA: return 32'd5;
            ALU_OR:           return 32'd6;
            ALU_AND:          return 32'd7;
            default:          return 32'd0;
        endcase
    endfunction

    // Reference encoder computed from the field layout with shifts/masks.
    function automatic exp_t enc_one(input enc_req_t r);
        logic [31:0] u, w, rd, rs1, rs2, ms, f3;
        int s;
        bit ill, rng;
        exp_t e;
        u = r.imm; s = signed'(r.imm);
        rd = 32'(r.rd); rs1 = 32'(r.rs1); rs2 = 32'(r.rs2);
        ms = 32'(r.mem_size);
        w = 0; ill = 0; rng = 0; f3 = 0;
        case (r.opcode)
            OP_LUI, OP_AUIPC: begin
                rng = (u & 32'hFFF) != 0;
                w = (u & 32'hFFFFF000) | (rd << 7) |
                    ((r.opcode == OP_LUI) ? 32'h37 : 32'h17);
            end
            OP_JAL: begin
                rng = s < -1048576 || s > 1048574 || (s % 2) != 0;
                w = (((u >> 20) & 1) << 31) | (((u >> 1) & 32'h3FF) << 21) |
                    (((u >> 11) & 1) << 20) | (((u >> 12) & 32'hFF) << 12) |
                    (rd << 7) | 32'h6F;
            end
            OP_JALR: begin
                rng = s < -2048 || s > 2047;
                w = ((u & 32'hFFF) << 20) | (rs1 << 15) | (rd << 7) | 32'h67;
            end
            OP_BRANCH: begin
                case (r.branch_op)
                    BR_EQ:  f3 = 0;
                    BR_NE:  f3 = 1;
                    BR_LT:  f3 = 4;
                    BR_GE:  f3 = 5;
                    BR_LTU: f3 = 6;
                    BR_GEU: f3 = 7;
                    default: ill = 1;
                endcase
                rng = s < -4096 || s > 4094 || (s % 2) != 0;
                w = (((u >> 12) & 1) << 31) | (((u >> 5) & 32'h3F) << 25) |
                    (rs2 << 20) | (rs1 << 15) | (f3 << 12) |
                    (((u >> 1) & 32'hF) << 8) | (((u >> 11) & 1) << 7) | 32'h63;
            end
            OP_LOAD: begin
                ill = !(ms == 0 || ms == 1 || ms == 2 || ms == 4 || ms == 5);
                rng = s < -2048 || s > 2047;
                w = ((u & 32'hFFF) << 20) | (rs1 << 15) | (ms << 12) |
                    (rd << 7) | 32'h03;
            end
            OP_STORE: begin
                ill = ms > 2;
                rng = s < -2048 || s > 2047;
                w = (((u >> 5) & 32'h7F) << 25) | (rs2 << 20) | (rs1 << 15) |
                    (ms << 12) | ((u & 32'h1F) << 7) | 32'h23;
            end
            OP_IMM: begin
                f3 = f3_of(r.alu_op);
                case (r.alu_op)
                    ALU_SLL, ALU_SRL, ALU_SRA: begin
                        rng = u > 31;
                        w = ((r.alu_op == ALU_SRA) ? 32'h40000000 : 0) |
                            ((u & 31) << 20) | (rs1 << 15) | (f3 << 12) |
                            (rd << 7) | 32'h13;
                    end
                    ALU_ADD, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_OR, ALU_AND: begin
                        rng = s < -2048 || s > 2047;
                        w = ((u & 32'hFFF) << 20) | (rs1 << 15) | (f3 << 12) |
                            (rd << 7) | 32'h13;
                    end
                    default: ill = 1;
                endcase
            end
            OP_REG: begin
                f3 = f3_of(r.alu_op);
                ill = r.alu_op > ALU_AND;
                w = ((r.alu_op == ALU_SUB || r.alu_op == ALU_SRA) ?
                     32'h40000000 : 0) | (rs2 << 20) | (rs1 << 15) |
                    (f3 << 12) | (rd << 7) | 32'h33;
            end
            default: ill = 1;
        endcase
        e.last = 1'b1;
        if (ill) begin
            e.err = 1'b1; e.w = 32'h13;
        end else if (rng) begin
            e.err = 1'b1; e.w = EOT ? 32'h13 : w;
        end else begin
            e.err = 1'b0; e.w = w;
        end
        return e;
    endfunction

    function automatic void push_model(input enc_req_t r);
`ifdef RV32_ENC_PSEUDO_EN
        logic [31:0] u, rd, hi;
        int s;
        exp_t e;
        if (r.opcode == OP_LI) begin
            u = r.imm; s = signed'(r.imm); rd = 32'(r.rd);
            if (s >= -2048 && s <= 2047) begin
                expq.push_back(enc_one(mk(OP_IMM, ALU_ADD, BR_EQ, 3'd0,
                                          r.rd, 5'd0, 5'd0, r.imm)));
            end else begin
                hi = (u + 32'h800) & 32'hFFFFF000;
                e.err = 1'b0;
                e.last = (u & 32'hFFF) == 0;
                e.w = hi | (rd << 7) | 32'h37;
                expq.push_back(e);
                if ((u & 32'hFFF) != 0) begin
                    e.last = 1'b1;
                    e.w = ((u & 32'hFFF) << 20) | (rd << 15) | (rd << 7) | 32'h13;
                    expq.push_back(e);
                end
            end
            return;
        end
`endif
        expq.push_back(enc_one(r));
    endfunction

    function automatic enc_req_t rand_req();
        enc_req_t r;
        int unsigned sel;
        r.opcode    = opcode_e'(4'($urandom_range(0, 10)));
        r.alu_op    = alu_op_e'(4'($urandom_range(0, 11)));
        r.branch_op = branch_op_e'(3'($urandom_range(0, 7)));
        r.mem_size  = 3'($urandom_range(0, 7));
        r.rd  = 5'($urandom);
        r.rs1 = 5'($urandom);
        r.rs2 = 5'($urandom);
        sel = $urandom_range(0, 3);
        case (sel)
            0: r.imm = $urandom;
            1: r.imm = $urandom_range(0, 4200) - 2100;
            2: r.imm = $urandom & 32'hFFFFF000;
            default: r.imm = $urandom_range(0, 32'h200020) - 32'h100010;
        endcase
        return r;
    endfunction

    task automatic one(input string tag, input enc_req_t r,
                       input logic [31:0] w, input logic e);
        req_i = r;
        req_valid_i = 1'b1;
        instr_ready_i = 1'b1;
        #1;
        chk1({tag, "_rdy"}, req_ready_o, 1'b1);
        chk1({tag, "_v_pre"}, instr_valid_o, 1'b0);
        @(posedge clk); #1;
        req_valid_i = 1'b0;
        chk1({tag, "_v"}, instr_valid_o, 1'b1);
        chk32({tag, "_w"}, instr_o, w);
        chk1({tag, "_last"}, instr_last_o, 1'b1);
        chk1({tag, "_err"}, err_o, e);
        @(posedge clk); #1;
        chk1({tag, "_v_post"}, instr_valid_o, 1'b0);
    endtask

    task automatic run_rand(input int nreq);
        int sent = 0;
        int cyc = 0;
        bit pop, acc;
        logic exp_rdy;
        enc_req_t r;
        while ((sent < nreq || expq.size() != 0) && cyc < LIMIT) begin
            if (expq.size() != 0) begin
                chk1("r_valid", instr_valid_o, 1'b1);
                chk32("r_word", instr_o, expq[0].w);
                chk1("r_last", instr_last_o, expq[0].last);
                chk1("r_err", err_o, expq[0].err);
            end else begin
                chk1("r_idle", instr_valid_o, 1'b0);
            end
            instr_ready_i = ($urandom_range(0, 3) != 0);
            #1;
            exp_rdy = (expq.size() == 0) ||
                      (expq.size() == 1 && instr_ready_i);
            chk1("r_rdy", req_ready_o, exp_rdy);
            pop = (expq.size() != 0) && instr_ready_i;
            acc = 0;
            r = rand_req();
            req_i = r;
            if (req_ready_o && sent < nreq && $urandom_range(0, 4) != 0) begin
                req_valid_i = 1'b1;
                acc = 1;
                sent++;
            end else begin
                req_valid_i = 1'b0;
            end
            @(posedge clk);
            if (pop) void'(expq.pop_front());
            if (acc) push_model(r);
            #1;
            cyc++;
        end
        req_valid_i = 1'b0;
        chk1("r_timeout", cyc < LIMIT, 1'b1);
    endtask

    initial begin
        rst_ni = 1'b0;
        req_valid_i = 1'b0;
        instr_ready_i = 1'b0;
        req_i = '0;
        #3;
        chk1("rst_valid", instr_valid_o, 1'b0);
        chk32("rst_instr", instr_o, 32'h0);
        chk1("rst_last", instr_last_o, 1'b0);
        chk1("rst_err", err_o, 1'b0);
        chk1("rst_rdy", req_ready_o, 1'b1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_ni = 1'b1;
        @(posedge clk); #1;

        one("add", mk(OP_REG, ALU_ADD, BR_EQ, 3'd0, 5'd3, 5'd1, 5'd2, 32'd0),
            32'h002081B3, 1'b0);
        one("addi_m1", mk(OP_IMM, ALU_ADD, BR_EQ, 3'd0, 5'd1, 5'd0, 5'd0,
            32'hFFFFFFFF), 32'hFFF00093, 1'b0);
        one("beq8", mk(OP_BRANCH, ALU_ADD, BR_EQ, 3'd0, 5'd0, 5'd1, 5'd2,
            32'd8), 32'h00208463, 1'b0);
        one("srai", mk(OP_IMM, ALU_SRA, BR_EQ, 3'd0, 5'd1, 5'd2, 5'd0,
            32'd3), 32'h40315093, 1'b0);
        one("addi_2048", mk(OP_IMM, ALU_ADD, BR_EQ, 3'd0, 5'd1, 5'd0, 5'd0,
            32'd2048), 32'h00000013, 1'b1);
        one("beq_odd", mk(OP_BRANCH, ALU_ADD, BR_EQ, 3'd0, 5'd0, 5'd1, 5'd2,
            32'd3), 32'h00000013, 1'b1);
        one("subi", mk(OP_IMM, ALU_SUB, BR_EQ, 3'd0, 5'd1, 5'd2, 5'd0,
            32'd1), 32'h00000013, 1'b1);

        // Back-pressure: output must hold and no new request accepted.
        instr_ready_i = 1'b0;
        req_i = mk(OP_REG, ALU_ADD, BR_EQ, 3'd0, 5'd3, 5'd1, 5'd2, 32'd0);
        req_valid_i = 1'b1;
        @(posedge clk); #1;
        req_i = mk(OP_REG, ALU_SUB, BR_EQ, 3'd0, 5'd5, 5'd6, 5'd7, 32'd0);
        for (int k = 0; k < 3; k++) begin
            chk1("bp_valid", instr_valid_o, 1'b1);
            chk32("bp_hold", instr_o, 32'h002081B3);
            chk1("bp_rdy", req_ready_o, 1'b0);
            @(posedge clk); #1;
        end
        instr_ready_i = 1'b1;
        #1;
        chk1("bp_rdy_rel", req_ready_o, 1'b1);
        @(posedge clk); #1;
        req_valid_i = 1'b0;
        chk32("bp_sub", instr_o, 32'h407302B3);
        @(posedge clk); #1;
        chk1("bp_idle", instr_valid_o, 1'b0);

        // Back-to-back stream, one word per cycle.
        for (int k = 1; k <= 4; k++) begin
            req_i = mk(OP_IMM, ALU_ADD, BR_EQ, 3'd0, 5'd1, 5'd0, 5'd0, 32'(k));
            req_valid_i = 1'b1;
            #1;
            chk1("b2b_rdy", req_ready_o, 1'b1);
            @(posedge clk); #1;
            chk1("b2b_valid", instr_valid_o, 1'b1);
            chk32("b2b_word", instr_o, (32'(k) << 20) | 32'h93);
        end
        req_valid_i = 1'b0;
        @(posedge clk); #1;
        chk1("b2b_idle", instr_valid_o, 1'b0);

`ifdef RV32_ENC_PSEUDO_EN
        req_i = mk(OP_LI, ALU_ADD, BR_EQ, 3'd0, 5'd5, 5'd0, 5'd0, 32'h12345FFF);
        req_valid_i = 1'b1;
        @(posedge clk); #1;
        req_valid_i = 1'b0;
        chk32("li_hi_w", instr_o, 32'h123462B7);
        chk1("li_hi_last", instr_last_o, 1'b0);
        chk1("li_hi_err", err_o, 1'b0);
        chk1("li_hi_rdy", req_ready_o, 1'b0);
        @(posedge clk); #1;
        chk1("li_lo_v", instr_valid_o, 1'b1);
        chk32("li_lo_w", instr_o, 32'hFFF28293);
        chk1("li_lo_last", instr_last_o, 1'b1);
        @(posedge clk); #1;
        chk1("li_idle", instr_valid_o, 1'b0);
        one("li_small", mk(OP_LI, ALU_ADD, BR_EQ, 3'd0, 5'd1, 5'd0, 5'd0,
            32'hFFFFFFFB), 32'hFFB00093, 1'b0);
        one("li_upper", mk(OP_LI, ALU_ADD, BR_EQ, 3'd0, 5'd1, 5'd0, 5'd0,
            32'h12345000), 32'h123450B7, 1'b0);
        req_i = mk(OP_LI, ALU_ADD, BR_EQ, 3'd0, 5'd5, 5'd0, 5'd0, 32'h12345FFF);
`else
        one("li_unsup", mk(OP_LI, ALU_ADD, BR_EQ, 3'd0, 5'd5, 5'd0, 5'd0,
            32'h12345FFF), 32'h00000013, 1'b1);
        req_i = mk(OP_REG, ALU_ADD, BR_EQ, 3'd0, 5'd3, 5'd1, 5'd2, 32'd0);
`endif
        // Reset while a word is held must drop it with nothing after release.
        req_valid_i = 1'b1;
        @(posedge clk); #1;
        req_valid_i = 1'b0;
        instr_ready_i = 1'b0;
        chk1("mr_valid", instr_valid_o, 1'b1);
        #1 rst_ni = 1'b0;
        #1;
        chk1("mr_async_v", instr_valid_o, 1'b0);
        chk32("mr_async_w", instr_o, 32'h0);
        @(posedge clk); #2;
        rst_ni = 1'b1;
        instr_ready_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk1("mr_no_emit", instr_valid_o, 1'b0);
        end

        run_rand(400);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have parameter ERR_ON_TRUNC, default 1: when 1, an out-of-range immediate emits NOP 0x00000013 with err_o set; when 0, the field is truncated and err_o is still set.
REQ-002 SHALL have port clk_i, input, 1: single clock, all state on its rising edge.
REQ-003 SHALL have port rst_ni, input, 1: reset, asynchronous, active-low.
REQ-004 SHALL have port req_valid_i, input, 1: request valid.
REQ-005 SHALL have port req_ready_o, output, 1: request accepted when valid&&ready.
REQ-006 SHALL have port req_i, input, enc_req_t: opcode_e, alu_op_e, branch_op_e, mem_size[2:0], rd/rs1/rs2[4:0], imm[31:0].
REQ-007 SHALL have port instr_valid_o, output, 1: encoded word valid.
REQ-008 SHALL have port instr_ready_i, input, 1: consumer ready.
REQ-009 SHALL have port instr_o, output, 32: encoded RV32I word.
REQ-010 SHALL have port instr_last_o, output, 1: final word of the current request.
REQ-011 SHALL have port err_o, output, 1: qualifies instr_o; illegal field or immediate.

Function
REQ-012 SHALL encode imm in the same convention as instruction_decoder (U-type imm is pre-shifted, B/J byte offsets), so encode(decode(w)) == w for every legal word.
REQ-013 SHALL have latency 1: a word accepted at edge N is valid after edge N; throughput is 1 word per cycle under continuous ready.
REQ-014 SHALL implement req_ready_o = (state==S_IDLE || (state==S_ONE && instr_ready_i)).
REQ-015 SHALL use states S_IDLE (output empty), S_ONE (holding single or last word), and S_LI_HI (holding LUI word, ADDI pending).
REQ-016 SHALL make these transitions: IDLE->ONE/LI_HI on accept; ONE->IDLE on output handshake without accept; ONE->ONE/LI_HI on handshake plus accept; LI_HI->ONE on handshake, loading the ADDI word.
REQ-017 SHALL hold instr_o, instr_last_o and err_o stable while instr_valid_o && !instr_ready_i.
REQ-018 SHALL apply these range checks: I/S -2048..2047; B -4096..4094 even; J -1048576..1048574 even; shamt 0..31; U imm[11:0]==0.
REQ-019 SHALL treat an unsupported opcode, or an alu_op illegal for that opcode (e.g. SUB on OP_IMM), as error: emit NOP with err_o=1 regardless of ERR_ON_TRUNC.
REQ-020 SHALL set funct7[5] for SUB, SRA and SRAI, and clear it otherwise.

Reset
REQ-021 SHALL, while rst_ni is low, force state=S_IDLE, instr_valid_o=0, instr_o=0, instr_last_o=0 and err_o=0, immediately and without waiting for a clock edge.
REQ-022 SHALL, on reset in S_LI_HI, discard the pending ADDI word, with no emission after release.

Configuration
REQ-023 SHALL, with RV32_ENC_PSEUDO_EN defined, accept pseudo-op LI (enc_req_t.opcode=OP_LI) as follows:
- imm in -2048..2047: one ADDI rd,x0,imm.
- imm[11:0]==0: one LUI.
- otherwise: LUI rd,(imm+0x800)>>12 then ADDI rd,rd,imm[11:0].
REQ-024 SHALL, without RV32_ENC_PSEUDO_EN, omit S_LI_HI, keep instr_last_o tied to 1, and treat OP_LI as unsupported per REQ-019.

Structure
REQ-025 SHALL place enc_req_t, OP_LI, the NOP constant and the range-limit constants in rv32_pkg, reusing the existing opcode_e, alu_op_e and branch_op_e.
REQ-026 SHALL use one combinational sub-module, instr_pack, that maps one enc_req_t to {word, err}; the FSM and output register stay in instr_encoder.

Verification
REQ-027 SHALL verify ADD x3,x1,x2 -> 0x002081B3, last=1, err=0, valid exactly one cycle after accept.
REQ-028 SHALL verify ADDI x1,x0,-1 -> 0xFFF00093; BEQ x1,x2,+8 -> 0x00208463.
REQ-029 SHALL verify that, with the macro defined, LI x5,0x12345FFF -> 0x123462B7 (last=0) then 0xFFF28293 (last=1), with req_ready_o=0 between the two words.
REQ-030 SHALL verify ADDI imm=2048 with ERR_ON_TRUNC=1 -> 0x00000013, err=1; BEQ offset +3 -> NOP, err=1.
REQ-031 SHALL verify that instr_ready_i=0 for 3 cycles keeps instr_o stable and req_ready_o=0, and that back-to-back requests under ready=1 give one word per cycle.
REQ-032 SHALL verify that asserting rst_ni low mid-LI (in S_LI_HI) drops valid asynchronously and emits no ADDI after release.
